// File: rtl/gt_scan_sequencer.sv
// Unsigned magnitude compare (GT/LT/MAX/MIN) that scans operands MSB nibble first through an external 4-bit slice.
// Latency is 1..NIB cycles after accept, depending on the first differing nibble; the result holds until out_ready.
module gt_scan_sequencer #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [1:0]       op,
   output logic [3:0]       nib_a,
   output logic [3:0]       nib_b,
   input  logic             gt_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             gt_flag,
   output logic             lt_flag,
   output logic             eq_flag,
   output logic [WIDTH-1:0] result
);

   localparam int NIB = WIDTH / 4;
   localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;

   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic [1:0]       op_q, op_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic             gt_q, gt_d, lt_q, lt_d, eq_q, eq_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [3:0]       cur_a, cur_b;

   assign cur_a = 4'(a_q >> {idx_q, 2'b00});
   assign cur_b = 4'(b_q >> {idx_q, 2'b00});

   // MAX/MIN fall through to A when neither flag is set, i.e. for equal operands.
   function automatic logic [WIDTH-1:0] pick(input logic [1:0] o, input logic g, input logic l,
                                             input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
      logic [WIDTH-1:0] r;
      case (o)
         2'b00:   r = {{(WIDTH-1){1'b0}}, g};
         2'b01:   r = {{(WIDTH-1){1'b0}}, l};
         2'b10:   r = (g || !l) ? x : y;
         default: r = (l || !g) ? x : y;
      endcase
      return r;
   endfunction

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      op_d    = op_q;
      idx_d   = idx_q;
      gt_d    = gt_q;
      lt_d    = lt_q;
      eq_d    = eq_q;
      res_d   = res_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d     = a;
               b_d     = b;
               op_d    = op;
               idx_d   = IW'(NIB - 1);
               state_d = SCAN;
            end
         end
         SCAN: begin
            if (cur_a != cur_b) begin
               gt_d    = gt_in;
               lt_d    = ~gt_in;
               eq_d    = 1'b0;
               res_d   = pick(op_q, gt_in, ~gt_in, a_q, b_q);
               state_d = DONE;
            end else if (idx_q == '0) begin
               gt_d    = 1'b0;
               lt_d    = 1'b0;
               eq_d    = 1'b1;
               res_d   = pick(op_q, 1'b0, 1'b0, a_q, b_q);
               state_d = DONE;
            end else begin
               idx_d = idx_q - 1'b1;
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= '0;
         idx_q   <= IW'(NIB - 1);
         gt_q    <= 1'b0;
         lt_q    <= 1'b0;
         eq_q    <= 1'b0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         op_q    <= op_d;
         idx_q   <= idx_d;
         gt_q    <= gt_d;
         lt_q    <= lt_d;
         eq_q    <= eq_d;
         res_q   <= res_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign nib_a     = (state_q == SCAN) ? cur_a : 4'h0;
   assign nib_b     = (state_q == SCAN) ? cur_b : 4'h0;
   assign gt_flag   = gt_q;
   assign lt_flag   = lt_q;
   assign eq_flag   = eq_q;
   assign result    = res_q;

endmodule

// File: tb/tb_gt_scan_sequencer.sv
// Bench for gt_scan_sequencer: directed vector table, reset-abort sequence, randomized ops vs. arithmetic model.
module tb_gt_scan_sequencer;
   localparam int WIDTH = 32;
   localparam int NIB   = WIDTH / 4;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a, b;
   logic [1:0]       op;
   logic [3:0]       nib_a, nib_b;
   logic             gt_in;
   logic             out_valid;
   logic             out_ready;
   logic             gt_flag, lt_flag, eq_flag;
   logic [WIDTH-1:0] result;

   int checks = 0;
   int errors = 0;

   gt_scan_sequencer #(.WIDTH(WIDTH)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .op(op), .nib_a(nib_a), .nib_b(nib_b), .gt_in(gt_in),
      .out_valid(out_valid), .out_ready(out_ready), .gt_flag(gt_flag),
      .lt_flag(lt_flag), .eq_flag(eq_flag), .result(result)
   );

   // External 4-bit greater-than slice.
   assign gt_in = (nib_a > nib_b);

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] va;
      logic [31:0] vb;
      logic [1:0]  vop;
      logic [31:0] eres;
      logic        egt;
      logic        elt;
      logic        eeq;
      int          elat;
      int          hold;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Reference: plain unsigned arithmetic; latency from the highest differing nibble.
   task automatic model(input logic [31:0] ma, input logic [31:0] mb, input logic [1:0] mop,
                        output logic [31:0] r, output logic g, output logic l, output logic e,
                        output int lat);
      bit found;
      g = (ma > mb);
      l = (ma < mb);
      e = (ma == mb);
      case (mop)
         2'd0: r = {31'd0, g};
         2'd1: r = {31'd0, l};
         2'd2: r = (ma >= mb) ? ma : mb;
         default: r = (ma <= mb) ? ma : mb;
      endcase
      lat = NIB;
      found = 0;
      for (int i = NIB - 1; i >= 0; i--) begin
         if (!found && (((ma >> (4 * i)) & 32'hF) != ((mb >> (4 * i)) & 32'hF))) begin
            lat = NIB - i;
            found = 1;
         end
      end
   endtask

   task automatic run_op(input vec_t v);
      int  k;
      bit  got;
      check("in_ready_idle", {31'd0, in_ready}, 32'd1);
      a = v.va; b = v.vb; op = v.vop; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      a = $urandom; b = $urandom; op = 2'($urandom_range(0, 3));
      check("in_ready_scan", {31'd0, in_ready}, 32'd0);
      check("nib_a_msb", {28'd0, nib_a}, {28'd0, v.va[31:28]});
      check("nib_b_msb", {28'd0, nib_b}, {28'd0, v.vb[31:28]});
      got = 0;
      k = 0;
      while (!got && k < 20) begin
         @(posedge clk); #1;
         k++;
         if (out_valid) got = 1;
      end
      if (!got) begin
         checks++;
         errors++;
         $display("FAIL out_valid_timeout: got none in %0d cycles expected latency %0d", k, v.elat);
         return;
      end
      check("latency", k, v.elat);
      check("gt_flag", {31'd0, gt_flag}, {31'd0, v.egt});
      check("lt_flag", {31'd0, lt_flag}, {31'd0, v.elt});
      check("eq_flag", {31'd0, eq_flag}, {31'd0, v.eeq});
      check("result", result, v.eres);
      check("nib_done", {24'd0, nib_a, nib_b}, 32'd0);
      for (int h = 0; h < v.hold; h++) begin
         in_valid = 1'b1;
         @(posedge clk); #1;
         check("hold_valid", {31'd0, out_valid}, 32'd1);
         check("hold_in_ready", {31'd0, in_ready}, 32'd0);
         check("hold_flags", {29'd0, gt_flag, lt_flag, eq_flag}, {29'd0, v.egt, v.elt, v.eeq});
         check("hold_result", result, v.eres);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("post_hs_valid", {31'd0, out_valid}, 32'd0);
      check("post_hs_ready", {31'd0, in_ready}, 32'd1);
   endtask

   vec_t vecs[7];
   vec_t rv;

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; op = '0;
      vecs[0] = '{32'hF0000000, 32'hE0000000, 2'd0, 32'h1,        1, 0, 0, 1, 0};
      vecs[1] = '{32'h12345678, 32'h12345678, 2'd2, 32'h12345678, 0, 0, 1, 8, 0};
      vecs[2] = '{32'h00000003, 32'h0000000F, 2'd3, 32'h00000003, 0, 1, 0, 8, 0};
      vecs[3] = '{32'h80000000, 32'h7FFFFFFF, 2'd1, 32'h0,        1, 0, 0, 1, 0};
      vecs[4] = '{32'h00000100, 32'h00000200, 2'd2, 32'h00000200, 0, 1, 0, 6, 5};
      vecs[5] = '{32'hDEADBEEF, 32'hDEADBEEF, 2'd3, 32'hDEADBEEF, 0, 0, 1, 8, 1};
      vecs[6] = '{32'h0000F000, 32'h0000E000, 2'd1, 32'h0,        1, 0, 0, 5, 2};

      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_flags", {29'd0, gt_flag, lt_flag, eq_flag}, 32'd0);
      check("rst_result", result, 32'd0);
      check("rst_nibs", {24'd0, nib_a, nib_b}, 32'd0);
      rst = 1'b0;

      for (int i = 0; i < 7; i++) run_op(vecs[i]);

      // Reset two edges into a scan; in_valid on the reset edge must not be taken.
      a = 32'h00001000; b = 32'h00000FFF; op = 2'd0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      check("abort_in_ready", {31'd0, in_ready}, 32'd1);
      check("abort_out_valid", {31'd0, out_valid}, 32'd0);
      check("abort_flags", {29'd0, gt_flag, lt_flag, eq_flag}, 32'd0);
      check("abort_result", result, 32'd0);
      check("abort_nibs", {24'd0, nib_a, nib_b}, 32'd0);
      begin
         int seen;
         seen = 0;
         for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (out_valid || !in_ready) seen++;
         end
         check("abort_no_valid", seen, 0);
      end

      for (int n = 0; n < 40; n++) begin
         logic [31:0] ra, rb;
         int sh;
         ra = $urandom;
         case ($urandom_range(0, 3))
            0: rb = $urandom;
            1: rb = ra;
            default: begin
               sh = $urandom_range(0, NIB - 1);
               rb = ra ^ (32'($urandom_range(1, 15)) << (4 * sh));
            end
         endcase
         rv.va = ra; rv.vb = rb; rv.vop = 2'($urandom_range(0, 3));
         rv.hold = $urandom_range(0, 3);
         model(rv.va, rv.vb, rv.vop, rv.eres, rv.egt, rv.elt, rv.eeq, rv.elat);
         run_op(rv);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/gt_scan_sequencer.md
GT_SCAN_SEQUENCER -- requirements
Module: gt_scan_sequencer

Interface
REQ-001 Parameter: WIDTH, 32, operand width in bits; SHALL be a multiple of 4, and NIB = WIDTH/4 nibbles.
REQ-002 Port: clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 Port: rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 Port: in_valid  input  1  upstream request valid.
REQ-005 Port: in_ready  output  1  block can accept a request.
REQ-006 Port: a  input  WIDTH  operand A, unsigned.
REQ-007 Port: b  input  WIDTH  operand B, unsigned.
REQ-008 Port: op  input  2  operation: 00 GT, 01 LT, 10 MAX, 11 MIN.
REQ-009 Port: nib_a  output  4  A nibble driven to the external 4-bit greater-than slice input a.
REQ-010 Port: nib_b  output  4  B nibble driven to the external 4-bit greater-than slice input b.
REQ-011 Port: gt_in  input  1  combinational Output of the external slice (nib_a > nib_b).
REQ-012 Port: out_valid  output  1  result valid.
REQ-013 Port: out_ready  input  1  downstream accepts result.
REQ-014 Port: gt_flag  output  1  A > B.
REQ-015 Port: lt_flag  output  1  A < B.
REQ-016 Port: eq_flag  output  1  A == B.
REQ-017 Port: result  output  WIDTH  operation result.

Function
REQ-018 FSM SHALL have exactly three states: IDLE, SCAN, DONE.
REQ-019 IDLE: in_ready=1; on in_valid&&in_ready the block SHALL latch a, b, op, set nibble index idx=NIB-1, and enter SCAN.
REQ-020 in_ready SHALL be 0 in SCAN and DONE; in_valid in those states SHALL be ignored.
REQ-021 SCAN: nib_a/nib_b SHALL present latched A[4*idx+3:4*idx]/B[4*idx+3:4*idx], with the MSB nibble first.
REQ-022 SCAN, nibbles unequal (internal 4-bit compare): register gt_flag=gt_in, lt_flag=~gt_in, eq_flag=0, and go to DONE.
REQ-023 SCAN, nibbles equal and idx==0: register eq_flag=1, gt_flag=0, lt_flag=0, and go to DONE.
REQ-024 SCAN, nibbles equal and idx>0: decrement idx and stay in SCAN.
REQ-025 Latency: out_valid SHALL rise k edges after the accept edge, where k = NIB - (index of the first differing nibble); for equal operands, k = NIB (8).
REQ-026 Result on op GT: {0, gt_flag}; LT: {0, lt_flag}; MAX: gt_flag ? A : B; MIN: lt_flag ? A : B (equal operands give A for both).
REQ-027 DONE: out_valid=1; flags and result SHALL hold stable until out_valid&&out_ready, then the block SHALL go to IDLE with out_valid=0 on the next cycle.
REQ-028 Back-to-back operation: the earliest next accept SHALL be the cycle after the handshake edge; there SHALL be no accept in DONE.
REQ-029 nib_a and nib_b SHALL be 0 in IDLE and DONE.
REQ-030 Comparison SHALL be unsigned; latched operands SHALL be immune to changes on a/b after the accept edge.

Reset
REQ-031 rst=1 at a clock edge SHALL force IDLE and set out_valid=0, in_ready=1, gt_flag=lt_flag=eq_flag=0, result=0, nib_a=nib_b=0, idx=NIB-1.
REQ-032 rst during SCAN or DONE SHALL abort the operation and discard it; no out_valid SHALL follow for that request.
REQ-033 rst SHALL take priority over in_valid and out_ready asserted on the same edge.

Verification
REQ-034 A=0xF0000000, B=0xE0000000, op GT -> out_valid 1 edge after accept, gt_flag=1, result=1.
REQ-035 A=B=0x12345678, op MAX -> out_valid 8 edges after accept, eq_flag=1, result=0x12345678.
REQ-036 A=0x00000003, B=0x0000000F, op MIN -> nibble 0 decides after 8 edges, lt_flag=1, result=0x00000003.
REQ-037 A=0x80000000, B=0x7FFFFFFF, op LT -> lt_flag=0, gt_flag=1, result=0 (unsigned check).
REQ-038 Hold out_ready=0 for 5 cycles in DONE -> flags/result stable, in_ready=0; release -> IDLE next cycle, new accept one cycle later.
REQ-039 Assert rst mid-SCAN (A=0x00001000, B=0x00000FFF, rst at the 2nd scan edge) -> outputs reach their reset values next edge, no out_valid pulse.
